sdram_rom_bridge: RTL and testbench

Upstream adapter for the SDRAM controller's 16-bit ROM/cart port. It turns single-cycle byte read/write strobes from the cartridge/CPU side into the controller's toggle request/acknowledge protocol. A one-word read buffer lets same-word reads skip SDRAM entirely. Byte writes are done as read-modify-write, because the ROM port has no byte masks.

---
 rtl/sdram_rom_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_sdram_rom_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rom_bridge.sv
// Byte-wide CPU/cartridge port onto the SDRAM controller's 16-bit toggle req/ack ROM port.
// One-word read buffer serves same-word reads; byte writes are read-modify-write through it.
//
// state  | meaning
// -------+---------------------------------------------------------------
// SYNC   | after reset: align mem_req to mem_ack so nothing is pending
// IDLE   | accepting strobes; read hits are served from the word buffer
// RD_ACK | read/fill request outstanding, waiting for mem_ack == mem_req
// RD_DLY | counting down until mem_dout holds the read word
// WR_ACK | write request outstanding, waiting for mem_ack == mem_req
module sdram_rom_bridge #(
    parameter int unsigned DOUT_DLY = 6
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic [23:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_dout,
    output logic        cpu_busy,
    input  logic        inv,
    output logic [22:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_we,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [15:0] mem_dout
);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_RD_ACK,
        ST_RD_DLY,
        ST_WR_ACK
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [22:0] buf_tag, buf_tag_nxt;
    logic [15:0] buf_data, buf_data_nxt;
    logic        buf_valid, buf_valid_nxt;
    logic        wr_pend, wr_pend_nxt;
    logic        inv_pend, inv_pend_nxt;
    logic        lat_sel, lat_sel_nxt;
    logic [7:0]  lat_din, lat_din_nxt;
    logic [7:0]  cpu_dout_nxt;
    logic [22:0] mem_addr_nxt;
    logic [15:0] mem_din_nxt;
    logic        mem_we_nxt;
    logic        mem_req_nxt;

    logic        ack_match;
    logic        buf_hit;
    logic [15:0] hit_merged;
    logic [15:0] fill_merged;

    function automatic logic [15:0] merge_byte(input logic [15:0] word, input logic sel,
                                               input logic [7:0] data);
        return sel ? {data, word[7:0]} : {word[15:8], data};
    endfunction

    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic sel);
        return sel ? word[15:8] : word[7:0];
    endfunction

    // An invalidate arriving with the strobe wins, so that access is a miss.
    assign ack_match   = (mem_ack == mem_req);
    assign buf_hit     = buf_valid && (buf_tag == cpu_addr[23:1]) && !inv;
    assign hit_merged  = merge_byte(buf_data, cpu_addr[0], cpu_din);
    assign fill_merged = merge_byte(mem_dout, lat_sel, lat_din);
    assign cpu_busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state     <= ST_SYNC;
            cnt       <= 4'd0;
            buf_tag   <= 23'd0;
            buf_data  <= 16'd0;
            buf_valid <= 1'b0;
            wr_pend   <= 1'b0;
            inv_pend  <= 1'b0;
            lat_sel   <= 1'b0;
            lat_din   <= 8'd0;
            cpu_dout  <= 8'd0;
            mem_addr  <= 23'd0;
            mem_din   <= 16'd0;
            mem_we    <= 1'b0;
            mem_req   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            buf_tag   <= buf_tag_nxt;
            buf_data  <= buf_data_nxt;
            buf_valid <= buf_valid_nxt;
            wr_pend   <= wr_pend_nxt;
            inv_pend  <= inv_pend_nxt;
            lat_sel   <= lat_sel_nxt;
            lat_din   <= lat_din_nxt;
            cpu_dout  <= cpu_dout_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_din   <= mem_din_nxt;
            mem_we    <= mem_we_nxt;
            mem_req   <= mem_req_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        buf_tag_nxt   = buf_tag;
        buf_data_nxt  = buf_data;
        buf_valid_nxt = buf_valid;
        wr_pend_nxt   = wr_pend;
        inv_pend_nxt  = inv_pend;
        lat_sel_nxt   = lat_sel;
        lat_din_nxt   = lat_din;
        cpu_dout_nxt  = cpu_dout;
        mem_addr_nxt  = mem_addr;
        mem_din_nxt   = mem_din;
        mem_we_nxt    = mem_we;
        mem_req_nxt   = mem_req;

        case (state)
            ST_SYNC: begin
                mem_req_nxt = mem_ack;
                state_nxt   = ST_IDLE;
            end

            ST_IDLE: begin
                if (inv) begin
                    buf_valid_nxt = 1'b0;
                end
                if (cpu_wr) begin
                    lat_sel_nxt  = cpu_addr[0];
                    lat_din_nxt  = cpu_din;
                    mem_addr_nxt = cpu_addr[23:1];
                    mem_req_nxt  = ~mem_req;
                    inv_pend_nxt = 1'b0;
                    if (buf_hit) begin
                        buf_data_nxt = hit_merged;
                        mem_din_nxt  = hit_merged;
                        mem_we_nxt   = 1'b1;
                        wr_pend_nxt  = 1'b0;
                        state_nxt    = ST_WR_ACK;
                    end else begin
                        mem_we_nxt  = 1'b0;
                        wr_pend_nxt = 1'b1;
                        state_nxt   = ST_RD_ACK;
                    end
                end else if (cpu_rd) begin
                    if (buf_hit) begin
                        cpu_dout_nxt = pick_byte(buf_data, cpu_addr[0]);
                    end else begin
                        lat_sel_nxt  = cpu_addr[0];
                        lat_din_nxt  = cpu_din;
                        mem_addr_nxt = cpu_addr[23:1];
                        mem_req_nxt  = ~mem_req;
                        mem_we_nxt   = 1'b0;
                        wr_pend_nxt  = 1'b0;
                        inv_pend_nxt = 1'b0;
                        state_nxt    = ST_RD_ACK;
                    end
                end
            end

            ST_RD_ACK: begin
                if (inv) begin
                    inv_pend_nxt = 1'b1;
                end
                if (ack_match) begin
                    cnt_nxt   = 4'(DOUT_DLY);
                    state_nxt = ST_RD_DLY;
                end
            end

            ST_RD_DLY: begin
                if (inv) begin
                    inv_pend_nxt = 1'b1;
                end
                cnt_nxt = cnt - 4'd1;
                // Capture on the cycle the count reaches zero, which is when mem_dout is valid.
                if (cnt <= 4'd1) begin
                    cnt_nxt       = 4'd0;
                    buf_tag_nxt   = mem_addr;
                    buf_valid_nxt = !(inv_pend || inv);
                    if (wr_pend) begin
                        buf_data_nxt = fill_merged;
                        mem_din_nxt  = fill_merged;
                        mem_we_nxt   = 1'b1;
                        mem_req_nxt  = ~mem_req;
                        wr_pend_nxt  = 1'b0;
                        state_nxt    = ST_WR_ACK;
                    end else begin
                        buf_data_nxt = mem_dout;
                        cpu_dout_nxt = pick_byte(mem_dout, lat_sel);
                        state_nxt    = ST_IDLE;
                    end
                end
            end

            ST_WR_ACK: begin
                if (inv) begin
                    buf_valid_nxt = 1'b0;
                end
                if (ack_match) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_SYNC;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_rom_bridge.sv
// Directed bench for sdram_rom_bridge: toggle-protocol controller model plus hand-computed vectors.
module tb_sdram_rom_bridge;

    localparam int DLY = 6;

    logic        clk = 1'b0;
    logic        init_n;
    logic [23:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic        cpu_busy;
    logic        inv;
    logic [22:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_dout;

    typedef struct {
        logic        we;
        logic [22:0] addr;
        logic [15:0] din;
        int          cyc;
    } req_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          toggles = 0;
    int          we_viol = 0;
    int          ack_cyc = 0;
    int          rd_ack_cyc = 0;
    int          ack_cnt = 0;
    bit          model_en = 1'b0;
    logic [15:0] mem_model [int];
    req_t        log_q [$];

    sdram_rom_bridge #(.DOUT_DLY(DLY)) dut (
        .clk      (clk),
        .init_n   (init_n),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_dout (cpu_dout),
        .cpu_busy (cpu_busy),
        .inv      (inv),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_req  (mem_req),
        .mem_ack  (mem_ack),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic strobe(input logic [23:0] a, input logic [7:0] d, input logic rd,
                          input logic wr, input logic iv);
        cpu_addr = a;
        cpu_din  = d;
        cpu_rd   = rd;
        cpu_wr   = wr;
        inv      = iv;
        step();
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        inv    = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int done_cyc);
        int n = 0;
        while (cpu_busy === 1'b1 && n < 300) begin
            step();
            n++;
        end
        check(tag, {31'd0, cpu_busy}, 32'd0);
        done_cyc = cyc;
    endtask

    // Controller model: ack two cycles after seeing a request, read word on mem_dout
    // for exactly the one cycle DLY cycles after the ack, garbage otherwise.
    initial begin : ctrl_model
        int          st = 0;
        int          w = 0;
        int          d = 0;
        logic [22:0] a;
        logic [15:0] dn;
        logic [15:0] word;
        logic        we;
        forever begin
            @(negedge clk);
            case (st)
                0: if (model_en && init_n && mem_req !== mem_ack) begin
                    a  = mem_addr;
                    we = mem_we;
                    dn = mem_din;
                    w  = 2;
                    st = 1;
                end
                1: begin
                    w--;
                    if (w == 0) begin
                        mem_ack = mem_req;
                        ack_cyc = cyc;
                        ack_cnt++;
                        if (we) begin
                            mem_model[int'(a)] = dn;
                            st = 0;
                        end else begin
                            rd_ack_cyc = cyc;
                            word = mem_model.exists(int'(a)) ? mem_model[int'(a)] : 16'h0000;
                            d  = DLY;
                            st = 2;
                        end
                    end
                end
                2: begin
                    d--;
                    if (d == 0) begin
                        mem_dout = word;
                        st = 3;
                    end
                end
                default: begin
                    mem_dout = 16'hDEAD;
                    st = 0;
                end
            endcase
        end
    end

    initial begin : req_monitor
        logic rp = 1'b0;
        logic wp = 1'b0;
        req_t r;
        forever begin
            @(negedge clk);
            if (mem_req !== rp) begin
                toggles++;
                r.we   = mem_we;
                r.addr = mem_addr;
                r.din  = mem_din;
                r.cyc  = cyc;
                log_q.push_back(r);
            end else if (mem_we !== wp) begin
                we_viol++;
            end
            rp = mem_req;
            wp = mem_we;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t0;
        int n0;
        int a0;
        int done;
        int n;

        init_n   = 1'b0;
        cpu_addr = 24'd0;
        cpu_din  = 8'd0;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
        inv      = 1'b0;
        mem_ack  = 1'b1;
        mem_dout = 16'hDEAD;
        mem_model[32'h80]   = 16'hBEEF;
        mem_model[32'h1000] = 16'h1234;
        mem_model[32'h100]  = 16'h5A5A;

        repeat (3) step();
        check("rst_busy",     {31'd0, cpu_busy}, 32'd1);
        check("rst_mem_req",  {31'd0, mem_req},  32'd0);
        check("rst_mem_we",   {31'd0, mem_we},   32'd0);
        check("rst_mem_addr", {9'd0, mem_addr},  32'd0);
        check("rst_mem_din",  {16'd0, mem_din},  32'd0);
        check("rst_cpu_dout", {24'd0, cpu_dout}, 32'd0);

        init_n = 1'b1;
        check("sync_busy", {31'd0, cpu_busy}, 32'd1);
        step();
        check("sync_mem_req",    {31'd0, mem_req},           32'd1);
        check("sync_no_pending", {31'd0, mem_req ^ mem_ack}, 32'd0);
        check("sync_idle",       {31'd0, cpu_busy},          32'd0);
        model_en = 1'b1;

        // read miss on 0x000101 -> high byte of 0xBEEF
        t0 = toggles;
        strobe(24'h000101, 8'h00, 1'b1, 1'b0, 1'b0);
        check("miss_busy",   {31'd0, cpu_busy},   32'd1);
        check("miss_toggle", toggles - t0,        32'd1);
        wait_idle("miss_idle", done);
        check("miss_toggles",  toggles - t0,        32'd1);
        check("miss_addr",     {9'd0, mem_addr},    32'h80);
        check("miss_we",       {31'd0, mem_we},     32'd0);
        check("miss_dout",     {24'd0, cpu_dout},   32'hBE);
        check("miss_latency",  done,                rd_ack_cyc + DLY + 1);

        // read hit on 0x000100 -> low byte, next cycle, no request
        t0 = toggles;
        strobe(24'h000100, 8'h00, 1'b1, 1'b0, 1'b0);
        check("hit_dout",    {24'd0, cpu_dout}, 32'hEF);
        check("hit_busy",    {31'd0, cpu_busy}, 32'd0);
        check("hit_toggles", toggles - t0,      32'd0);

        // write hit 0x55 -> 0x000100 on 0xBEEF
        t0 = toggles;
        strobe(24'h000100, 8'h55, 1'b0, 1'b1, 1'b0);
        wait_idle("wrhit_idle", done);
        check("wrhit_toggles", toggles - t0,     32'd1);
        check("wrhit_we",      {31'd0, mem_we},  32'd1);
        check("wrhit_din",     {16'd0, mem_din}, 32'hBE55);
        check("wrhit_latency", done,             ack_cyc + 1);
        t0 = toggles;
        strobe(24'h000101, 8'h00, 1'b1, 1'b0, 1'b0);
        check("wrhit_readback", {24'd0, cpu_dout}, 32'hBE);
        check("wrhit_rb_tog",   toggles - t0,      32'd0);

        // write miss 0xAA -> 0x002001, memory word 0x1234
        t0 = toggles;
        n0 = log_q.size();
        strobe(24'h002001, 8'hAA, 1'b0, 1'b1, 1'b0);
        wait_idle("wrmiss_idle", done);
        check("wrmiss_toggles", toggles - t0, 32'd2);
        if (log_q.size() >= n0 + 2) begin
            check("wrmiss_fill_we",   {31'd0, log_q[n0].we},     32'd0);
            check("wrmiss_fill_addr", {9'd0, log_q[n0].addr},    32'h1000);
            check("wrmiss_wr_we",     {31'd0, log_q[n0+1].we},   32'd1);
            check("wrmiss_wr_din",    {16'd0, log_q[n0+1].din},  32'hAA34);
            check("wrmiss_wr_time",   log_q[n0+1].cyc,           rd_ack_cyc + DLY + 1);
        end
        check("wrmiss_done", done, ack_cyc + 1);
        t0 = toggles;
        strobe(24'h002000, 8'h00, 1'b1, 1'b0, 1'b0);
        check("wrmiss_readback", {24'd0, cpu_dout}, 32'h34);
        check("wrmiss_rb_tog",   toggles - t0,      32'd0);

        // inv pulsed during RD_DLY of a read to 0x000200
        t0 = toggles;
        a0 = ack_cnt;
        strobe(24'h000200, 8'h00, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (ack_cnt == a0 && n < 50) begin
            step();
            n++;
        end
        check("inv_ack_seen", {31'd0, ack_cnt != a0}, 32'd1);
        step();
        inv = 1'b1;
        step();
        inv = 1'b0;
        wait_idle("inv_idle", done);
        check("inv_dout",    {24'd0, cpu_dout}, 32'h5A);
        check("inv_toggles", toggles - t0,      32'd1);
        t0 = toggles;
        strobe(24'h000200, 8'h00, 1'b1, 1'b0, 1'b0);
        wait_idle("inv_rerd_idle", done);
        check("inv_reread_tog",  toggles - t0,      32'd1);
        check("inv_reread_dout", {24'd0, cpu_dout}, 32'h5A);

        // inv and read strobe in the same IDLE cycle: a miss
        t0 = toggles;
        strobe(24'h000200, 8'h00, 1'b1, 1'b0, 1'b1);
        wait_idle("invrd_idle", done);
        check("invrd_toggles", toggles - t0, 32'd1);

        // rd+wr together, then strobes while busy
        t0 = toggles;
        strobe(24'h000200, 8'h77, 1'b1, 1'b1, 1'b0);
        check("both_busy", {31'd0, cpu_busy}, 32'd1);
        strobe(24'h000400, 8'h11, 1'b1, 1'b0, 1'b0);
        strobe(24'h000402, 8'h22, 1'b0, 1'b1, 1'b0);
        wait_idle("both_idle", done);
        repeat (6) step();
        check("both_toggles", toggles - t0,      32'd1);
        check("both_we",      {31'd0, mem_we},   32'd1);
        check("both_din",     {16'd0, mem_din},  32'h5A77);
        check("both_addr",    {9'd0, mem_addr},  32'h100);

        // reset in the middle of an access with the request left pending
        model_en = 1'b0;
        strobe(24'h000800, 8'h00, 1'b1, 1'b0, 1'b0);
        check("midrst_pending", {31'd0, mem_req ^ mem_ack}, 32'd1);
        init_n = 1'b0;
        #1;
        check("midrst_req",  {31'd0, mem_req},  32'd0);
        check("midrst_busy", {31'd0, cpu_busy}, 32'd1);
        step();
        init_n = 1'b1;
        step();
        check("midrst_resync", {31'd0, mem_req ^ mem_ack}, 32'd0);
        check("midrst_idle",   {31'd0, cpu_busy},          32'd0);
        model_en = 1'b1;
        t0 = toggles;
        repeat (5) step();
        check("midrst_quiet", toggles - t0, 32'd0);
        strobe(24'h000100, 8'h00, 1'b1, 1'b0, 1'b0);
        wait_idle("midrst_rd_idle", done);
        check("midrst_rd_tog",  toggles - t0,      32'd1);
        check("midrst_rd_dout", {24'd0, cpu_dout}, 32'h55);

        check("we_only_on_toggle", we_viol, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
